address_decoder: RTL and testbench

- Memory-map decoder for the 16-bit CPU bus.
- Splits the address space into three regions: RAM (0x0000–0xCFFF), IO (0xD000–0xDFFF) and ROM (0xE000–0xFFFF).
- Drives active-low chip selects combinationally from the bus address.
- Also provides a registered region/bank record of the last decoded access for debug and bus monitors.

---
 rtl/addr_map_pkg.sv | 18 +
 rtl/region_compare.sv | 26 ++
 rtl/address_decoder.sv | 72 +++++++
 tb/tb_address_decoder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/addr_map_pkg.sv
// rtl/addr_map_pkg.sv - shared memory-map constants for the CPU bus address decoder
//
// Purpose: region codes reported on region_q and the default region boundaries.
// Ports:   none (package).

package addr_map_pkg;

    typedef logic [1:0] region_t;

    localparam region_t REGION_RAM  = 2'd0;
    localparam region_t REGION_IO   = 2'd1;
    localparam region_t REGION_ROM  = 2'd2;
    localparam region_t REGION_NONE = 2'd3;

    localparam logic [15:0] IO_BASE_DEFAULT  = 16'hD000;
    localparam logic [15:0] ROM_BASE_DEFAULT = 16'hE000;

endpackage

// File: rtl/region_compare.sv
// rtl/region_compare.sv - combinational address-to-region classifier
//
// Purpose: maps a bus address onto RAM / IO / ROM using unsigned magnitude
//          compares against the two region boundaries.
// Ports:
//   address  in   ADDR_W  bus address
//   region   out  2       REGION_RAM / REGION_IO / REGION_ROM

module region_compare
    import addr_map_pkg::*;
#(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  IO_BASE  = IO_BASE_DEFAULT,
    parameter logic [ADDR_W-1:0]  ROM_BASE = ROM_BASE_DEFAULT
) (
    input  logic [ADDR_W-1:0] address,
    output region_t           region
);

    // Conditional operators rather than if/else so an unknown address
    // yields an unknown region instead of silently falling into a branch.
    assign region = (address < IO_BASE)  ? REGION_RAM :
                    (address < ROM_BASE) ? REGION_IO  :
                                           REGION_ROM;

endmodule

// File: rtl/address_decoder.sv
// rtl/address_decoder.sv - CPU bus memory-map decoder with active-low chip selects
//
// Purpose: zero-latency chip selects for RAM / IO / ROM plus a registered
//          record of the previous cycle's region and bank for bus monitors.
// Ports:
//   clk       in   1       system clock, rising edge
//   reset     in   1       synchronous, active-high reset
//   address   in   ADDR_W  CPU bus address
//   ram_sel   out  1       RAM chip select, active low
//   rom_sel   out  1       ROM chip select, active low
//   io_sel    out  1       IO chip select, active low
//   region_q  out  2       previous cycle's region code (3 = none)
//   bank_q    out  4       previous cycle's top four address bits
//   ready     out  1       high once out of reset

module address_decoder
    import addr_map_pkg::*;
#(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  IO_BASE  = IO_BASE_DEFAULT,
    parameter logic [ADDR_W-1:0]  ROM_BASE = ROM_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic              ram_sel,
    output logic              rom_sel,
    output logic              io_sel,
    output logic [1:0]        region_q,
    output logic [3:0]        bank_q,
    output logic              ready
);

    generate
        if (IO_BASE >= ROM_BASE) begin : g_bad_map
            $error("address_decoder: IO_BASE must be below ROM_BASE");
        end
    endgenerate

    region_t region;
    logic    sel_enable;

    region_compare #(
        .ADDR_W   (ADDR_W),
        .IO_BASE  (IO_BASE),
        .ROM_BASE (ROM_BASE)
    ) u_region_compare (
        .address (address),
        .region  (region)
    );

    // Reset is folded in combinationally so the address presented during the
    // reset cycle is never selected, even though ready only falls at the edge.
    assign sel_enable = ready & ~reset;

    assign ram_sel = ~(sel_enable & (region == REGION_RAM));
    assign io_sel  = ~(sel_enable & (region == REGION_IO));
    assign rom_sel = ~(sel_enable & (region == REGION_ROM));

    always_ff @(posedge clk) begin
        if (reset) begin
            ready    <= 1'b0;
            region_q <= REGION_NONE;
            bank_q   <= 4'h0;
        end else begin
            ready    <= 1'b1;
            region_q <= ready ? region : REGION_NONE;
            bank_q   <= address[ADDR_W-1:ADDR_W-4];
        end
    end

endmodule

// File: tb/tb_address_decoder.sv
// tb/tb_address_decoder.sv - self-checking bench for address_decoder

module tb_address_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        ram_sel, rom_sel, io_sel;
    logic [1:0]  region_q;
    logic [3:0]  bank_q;
    logic        ready;

    int checks = 0;
    int errors = 0;

    // reference state: what the previous cycle should have left behind
    bit       model_known = 0;
    bit       ready_m     = 0;
    int       region_m    = 3;
    int       bank_m      = 0;

    address_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .ram_sel  (ram_sel),
        .rom_sel  (rom_sel),
        .io_sel   (io_sel),
        .region_q (region_q),
        .bank_q   (bank_q),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        ram;
        logic        rom;
        logic        io;
        int          region;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Region from the memory map: RAM below 0xD000, IO up to 0xDFFF, ROM above.
    function automatic int ref_region(input logic [15:0] a);
        int v;
        v = int'(a);
        if (v < 53248) return 0;
        if (v < 57344) return 1;
        return 2;
    endfunction

    // Called just after a rising edge; applies one cycle of stimulus and checks
    // both the combinational selects and the registered outputs after the edge.
    task automatic cycle(input logic [15:0] a, input logic r);
        int rg;
        bit en;
        address = a;
        reset   = r;
        rg      = ref_region(a);
        #1;
        if (model_known) begin
            en = ready_m && !r;
            chk("ram_sel", ram_sel, !(en && rg == 0));
            chk("io_sel",  io_sel,  !(en && rg == 1));
            chk("rom_sel", rom_sel, !(en && rg == 2));
            chk("sel_count", 32'($countones({ram_sel, rom_sel, io_sel})), en ? 2 : 3);
        end
        @(posedge clk);
        region_m    = r ? 3 : (ready_m ? rg : 3);
        bank_m      = r ? 0 : int'(a[15:12]);
        ready_m     = !r;
        model_known = 1;
        #1;
        chk("region_q", region_q, region_m);
        chk("bank_q",   bank_q,   bank_m);
        chk("ready",    ready,    ready_m);
    endtask

    initial begin
        address = 16'h0000;
        reset   = 1'b1;

        for (int i = 0; i <= 12; i++)
            tbl.push_back('{16'(i * 16'h1000), 1'b0, 1'b1, 1'b1, 0});
        tbl.push_back('{16'hCFFF, 1'b0, 1'b1, 1'b1, 0});
        tbl.push_back('{16'hD000, 1'b1, 1'b1, 1'b0, 1});
        tbl.push_back('{16'hDFFF, 1'b1, 1'b1, 1'b0, 1});
        tbl.push_back('{16'hE000, 1'b1, 1'b0, 1'b1, 2});
        tbl.push_back('{16'hF000, 1'b1, 1'b0, 1'b1, 2});
        tbl.push_back('{16'hFFFF, 1'b1, 1'b0, 1'b1, 2});
        tbl.push_back('{16'h0000, 1'b0, 1'b1, 1'b1, 0});

        // reset held for two cycles, then released
        cycle(16'h0000, 1'b1);
        cycle(16'h0000, 1'b1);
        chk("reset_region_q", region_q, 3);
        chk("reset_ready", ready, 0);
        cycle(16'h0000, 1'b0);
        chk("ready_after_release", ready, 1);
        address = 16'h0000;
        #1;
        chk("ram_sel_after_release", ram_sel, 0);
        @(posedge clk);
        #1;
        ready_m  = 1;
        region_m = 0;
        bank_m   = 0;

        // fixed vectors: walk, region edges, boundaries
        foreach (tbl[i]) begin
            address = tbl[i].addr;
            reset   = 1'b0;
            #1;
            chk("tbl_ram_sel", ram_sel, tbl[i].ram);
            chk("tbl_rom_sel", rom_sel, tbl[i].rom);
            chk("tbl_io_sel",  io_sel,  tbl[i].io);
            #1;
            cycle(tbl[i].addr, 1'b0);
            chk("tbl_region_q", region_q, tbl[i].region);
            chk("tbl_bank_q",   bank_q,   tbl[i].addr[15:12]);
        end

        // mid-operation reset with an IO address on the bus
        cycle(16'hD123, 1'b0);
        chk("pre_reset_region_q", region_q, 1);
        address = 16'hD123;
        reset   = 1'b1;
        #1;
        chk("io_sel_in_reset_cycle", io_sel, 1);
        #1;
        cycle(16'hD123, 1'b1);
        chk("region_q_after_reset_edge", region_q, 3);
        cycle(16'hD123, 1'b0);
        chk("region_q_cycle_after_reset", region_q, 3);
        cycle(16'hD123, 1'b0);
        chk("region_q_recovered", region_q, 1);

        // random sweep against the reference map
        for (int i = 0; i < 1000; i++)
            cycle(16'($urandom), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
